// File: rtl/timer_pkg.sv
// +--------------------------------------------------------------------------+
// | timer_pkg: constants and FSM encoding shared with the advanced timer     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package timer_pkg;

  localparam logic [3:0] PATTERN_DEF = 4'b1101;
  localparam int         DELAY_W_DEF = 4;
  localparam int         UNIT_CYCLES = 1000;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SEND_PAT  = 3'd1;
  localparam logic [2:0] ST_SEND_DLY  = 3'd2;
  localparam logic [2:0] ST_WAIT_CNT  = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_ACK       = 3'd5;
  localparam logic [2:0] ST_GAP       = 3'd6;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    SEND_PAT  = ST_SEND_PAT,
    SEND_DLY  = ST_SEND_DLY,
    WAIT_CNT  = ST_WAIT_CNT,
    WAIT_DONE = ST_WAIT_DONE,
    ACK       = ST_ACK,
    GAP       = ST_GAP
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/piso_shift8.sv
// +--------------------------------------------------------------------------+
// | piso_shift8: 8-bit parallel-load, MSB-first serial-out shift register    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module piso_shift8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] par_data,
  output logic       ser_bit
);

  logic [7:0] r_sr;

  // Zeros are shifted in so the line idles low once the word is out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr <= '0;
    end else if (load) begin
      r_sr <= par_data;
    end else if (shift) begin
      r_sr <= {r_sr[6:0], 1'b0};
    end
  end

  assign ser_bit = r_sr[7];

endmodule

`default_nettype wire

// File: rtl/timer_cmd_serializer.sv
// +--------------------------------------------------------------------------+
// | timer_cmd_serializer: serialises pattern+delay to the timer, tracks it   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module timer_cmd_serializer
  import timer_pkg::*;
#(
  parameter logic [3:0] PATTERN     = PATTERN_DEF,
  parameter int         DELAY_W     = DELAY_W_DEF,
  parameter int         CNT_TIMEOUT = 4,
  parameter int         GAP_CYCLES  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [DELAY_W-1:0] cmd_delay,
  output logic               data_out,
  input  logic               counting_in,
  input  logic               done_in,
  output logic               ack_out,
  output logic               busy,
  output logic               cmd_complete,
  output logic               cmd_error
);

  localparam int            CW       = $clog2(max2(CNT_TIMEOUT, GAP_CYCLES) + 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(CNT_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  state_t        r_state;
  logic [2:0]    r_bit_cnt;
  logic [CW-1:0] r_wait_cnt;
  logic          w_load;
  logic          w_shift;

  assign w_load    = (r_state == IDLE) && cmd_valid;
  assign w_shift   = (r_state == SEND_PAT) || (r_state == SEND_DLY);
  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);

  piso_shift8 u_piso (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .shift    (w_shift),
    .par_data ({PATTERN, cmd_delay}),
    .ser_bit  (data_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_wait_cnt   <= '0;
      ack_out      <= 1'b0;
      cmd_complete <= 1'b0;
      cmd_error    <= 1'b0;
    end else begin
      ack_out      <= 1'b0;
      cmd_complete <= 1'b0;
      cmd_error    <= 1'b0;
      case (r_state)
        IDLE: begin
          r_bit_cnt  <= '0;
          r_wait_cnt <= '0;
          if (cmd_valid) r_state <= SEND_PAT;
        end
        SEND_PAT: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd3) r_state <= SEND_DLY;
        end
        SEND_DLY: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) r_state <= WAIT_CNT;
        end
        WAIT_CNT: begin
          // A late counting_in on the timeout edge still wins.
          if (counting_in) begin
            r_state    <= WAIT_DONE;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == TO_LAST) begin
            cmd_error  <= 1'b1;
            r_state    <= GAP;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (done_in) begin
            r_state      <= ACK;
            ack_out      <= 1'b1;
            cmd_complete <= 1'b1;
          end
        end
        ACK: begin
          r_state    <= GAP;
          r_wait_cnt <= '0;
        end
        GAP: begin
          if (r_wait_cnt == GAP_LAST) r_state <= IDLE;
          else r_wait_cnt <= r_wait_cnt + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
